// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add multiply, restoring divide).
// One radix-2 step per cycle over 32 cycles; divide-by-zero and signed overflow
// bypass the iteration and complete in one cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [2:0]      OP_MUL   = 3'b000;
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]      op_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] dvsr_q;
  logic            neg_q;
  logic [PW-1:0]   prod_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_d, done_d;

  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf, special, neg_init;
  logic [XLEN-1:0] a_mag, b_mag, special_val;
  logic [PW-1:0]   prod_init;

  // Decode the incoming request: operand magnitudes, result sign, special cases.
  always_comb begin
    is_div      = op[2];
    a_sgn       = is_div ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn       = is_div ? ~op[0] : ~op[1];
    a_neg       = a_sgn & a[XLEN-1];
    b_neg       = b_sgn & b[XLEN-1];
    a_mag       = a_neg ? XLEN'(-a) : a;
    b_mag       = b_neg ? XLEN'(-b) : b;
    neg_init    = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
    prod_init   = is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
    div_zero    = is_div && (b == '0);
    div_ovf     = is_div && ~op[0] && (a == SMIN) && (b == '1);
    special     = div_zero | div_ovf;
    special_val = '0;
    if (div_zero) begin
      special_val = op[1] ? a : '1;
    end else if (div_ovf) begin
      special_val = op[1] ? '0 : SMIN;
    end
  end

  logic [XLEN:0]   mul_sum, rem_shift;
  logic [XLEN-1:0] rem_diff;
  logic            rem_ge;
  logic [PW-1:0]   mul_step, div_step, prod_step;

  // One radix-2 iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_step  = {mul_sum, prod_q[XLEN-1:1]};
    rem_shift = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
    rem_ge    = (rem_shift >= {1'b0, dvsr_q});
    rem_diff  = rem_shift[XLEN-1:0] - dvsr_q;
    div_step  = {(rem_ge ? rem_diff : rem_shift[XLEN-1:0]), prod_q[XLEN-2:0], rem_ge};
    prod_step = op_q[2] ? div_step : mul_step;
  end

  logic [PW-1:0]   prod_signed;
  logic [XLEN-1:0] quo, rmd, calc_val;

  // Apply the result sign to the final step and select the architectural result.
  always_comb begin
    prod_signed = neg_q ? PW'(-prod_step) : prod_step;
    quo         = neg_q ? XLEN'(-prod_step[XLEN-1:0]) : prod_step[XLEN-1:0];
    rmd         = neg_q ? XLEN'(-prod_step[PW-1:XLEN]) : prod_step[PW-1:XLEN];
    if (op_q[2]) begin
      calc_val = op_q[1] ? rmd : quo;
    end else if (op_q == OP_MUL) begin
      calc_val = prod_signed[XLEN-1:0];
    end else begin
      calc_val = prod_signed[PW-1:XLEN];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = special ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done can be registered.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, write result entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      mcand_q <= '0;
      dvsr_q  <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      cnt_q   <= '0;
      result  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            mcand_q <= a_mag;
            dvsr_q  <= b_mag;
            neg_q   <= neg_init;
            prod_q  <= prod_init;
            cnt_q   <= '0;
            if (special) result <= special_val;
          end
        end
        S_CALC: begin
          prod_q <= prod_step;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) result <= calc_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Count done pulses independently of the transaction task.
  always @(posedge clk) if (done) done_pulses <= done_pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, scramble inputs after accept, optionally pulse start mid-flight.
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                     input int inject_at);
    int lat;
    int busy_cnt;
    int pulses0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    pulses0 = done_pulses;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      if (lat == inject_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    @(posedge clk); #1;
    check({tag, " done_low_after"}, 32'(done), 32'd0);
    check({tag, " busy_low_after"}, 32'(busy), 32'd0);
    check({tag, " result_held"}, result, exp);
    check({tag, " one_pulse"}, 32'(done_pulses - pulses0), 32'd1);
  endtask

  initial begin
    int pulses0;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    run("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run("mulhsu",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0);
    run("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run("divu",    3'b101, 32'd100,      32'd7,        32'd14,       33, 0);
    run("remu",    3'b111, 32'd100,      32'd7,        32'd2,        33, 0);
    run("div_neg", 3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33, 0);
    run("rem_neg", 3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33, 0);
    run("div_nd",  3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33, 0);
    run("rem_nd",  3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        33, 0);
    run("div0",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run("divu0",   3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run("rem0",    3'b110, 32'd5,        32'd0,        32'd5,        1,  0);
    run("remu0",   3'b111, 32'd5,        32'd0,        32'd5,        1,  0);
    run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
    run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);
    run("mul_inj", 3'b000, 32'd1234,     32'd5678,     32'd7006652,  33, 10);

    // Abort an operation in the middle of CALC.
    @(negedge clk);
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", result, 32'd0);
    pulses0 = done_pulses;
    repeat (40) @(posedge clk);
    #1;
    check("abort no_pulse", 32'(done_pulses - pulses0), 32'd0);
    check("abort result_stays", result, 32'd0);
    run("mul_after_abort", 3'b000, 32'd3, 32'd4, 32'd12, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
